// File: rtl/denetim_birimi_if.sv
// Fetch, decode-output and data-memory signals between the RV32I control unit and the datapath.
// The control unit is the master side.
interface denetim_birimi_if;
   logic        buyruk_istek_o;
   logic        buyruk_gecerli_i;
   logic [31:0] buyruk_i;
   logic [31:0] ps_o;
   logic        amb_secim_o;
   logic [3:0]  amb_fonksiyon_o;
   logic [31:0] sabit_genisletici_o;
   logic [4:0]  rs1_adres_o;
   logic [4:0]  rs2_adres_o;
   logic [4:0]  rd_adres_o;
   logic        yazmac_yaz_o;
   logic        yaz_kaynak_o;
   logic        bellek_istek_o;
   logic        bellek_yaz_o;
   logic        bellek_hazir_i;
   logic        gecersiz_buyruk_o;

   modport master (
      output buyruk_istek_o, ps_o, amb_secim_o, amb_fonksiyon_o, sabit_genisletici_o,
             rs1_adres_o, rs2_adres_o, rd_adres_o, yazmac_yaz_o, yaz_kaynak_o,
             bellek_istek_o, bellek_yaz_o, gecersiz_buyruk_o,
      input  buyruk_gecerli_i, buyruk_i, bellek_hazir_i
   );

   modport slave (
      input  buyruk_istek_o, ps_o, amb_secim_o, amb_fonksiyon_o, sabit_genisletici_o,
             rs1_adres_o, rs2_adres_o, rd_adres_o, yazmac_yaz_o, yaz_kaynak_o,
             bellek_istek_o, bellek_yaz_o, gecersiz_buyruk_o,
      output buyruk_gecerli_i, buyruk_i, bellek_hazir_i
   );
endinterface

// File: rtl/denetim_birimi.sv
// Multi-cycle control unit for an RV32I subset (R/I ALU ops, LW, SW).
// Decode is combinational from the latched instruction; strobes are registered FSM outputs.
module denetim_birimi (
   input  logic             clk_i,
   input  logic             rst_ni,
   denetim_birimi_if.master bus
);
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [6:0]  OP_R  = 7'b0110011;
   localparam logic [6:0]  OP_I  = 7'b0010011;
   localparam logic [6:0]  OP_LW = 7'b0000011;
   localparam logic [6:0]  OP_SW = 7'b0100011;

   typedef enum logic [2:0] {GETIR, COZ, YURUT, BELLEK, GERI_YAZ, HATA} durum_t;

   durum_t      r_durum;
   logic [31:0] r_buyruk;
   logic [31:0] r_ps;
   logic        r_buyruk_istek, r_bellek_istek, r_bellek_yaz, r_yazmac_yaz, r_gecersiz;

   logic [6:0]  w_opcode, w_f7;
   logic [2:0]  w_f3;
   logic [4:0]  w_rd;
   logic [31:0] w_imm_i, w_imm_s, w_imm;
   logic [3:0]  w_fonk;
   logic        w_gecerli, w_secim, w_kaynak, w_sw, w_bellek_op;

   assign w_opcode    = r_buyruk[6:0];
   assign w_f3        = r_buyruk[14:12];
   assign w_f7        = r_buyruk[31:25];
   assign w_rd        = r_buyruk[11:7];
   assign w_imm_i     = {{20{r_buyruk[31]}}, r_buyruk[31:20]};
   assign w_imm_s     = {{20{r_buyruk[31]}}, r_buyruk[31:25], r_buyruk[11:7]};
   assign w_sw        = (w_opcode == OP_SW);
   assign w_bellek_op = w_sw || (w_opcode == OP_LW);

   // Anything not explicitly matched leaves w_gecerli low and lands in HATA.
   always_comb begin
      w_gecerli = 1'b0;
      w_fonk    = 4'b0000;
      w_secim   = 1'b0;
      w_kaynak  = 1'b0;
      w_imm     = 32'h0;
      case (w_opcode)
         OP_R: begin
            case (w_f3)
               3'b000: begin
                  if (w_f7 == 7'b0000000) begin
                     w_gecerli = 1'b1;
                     w_fonk    = 4'b0000;
                  end else if (w_f7 == 7'b0100000) begin
                     w_gecerli = 1'b1;
                     w_fonk    = 4'b0001;
                  end
               end
               3'b111: begin w_gecerli = (w_f7 == 7'b0); w_fonk = 4'b0010; end
               3'b100: begin w_gecerli = (w_f7 == 7'b0); w_fonk = 4'b0011; end
               3'b110: begin w_gecerli = (w_f7 == 7'b0); w_fonk = 4'b0100; end
               default: ;
            endcase
         end
         OP_I: begin
            w_secim = 1'b1;
            w_imm   = w_imm_i;
            case (w_f3)
               3'b000: begin w_gecerli = 1'b1; w_fonk = 4'b0000; end
               3'b111: begin w_gecerli = 1'b1; w_fonk = 4'b0010; end
               3'b100: begin w_gecerli = 1'b1; w_fonk = 4'b0011; end
               3'b110: begin w_gecerli = 1'b1; w_fonk = 4'b0100; end
               default: ;
            endcase
         end
         OP_LW: begin
            w_gecerli = (w_f3 == 3'b010);
            w_secim   = 1'b1;
            w_kaynak  = 1'b1;
            w_imm     = w_imm_i;
         end
         OP_SW: begin
            w_gecerli = (w_f3 == 3'b010);
            w_secim   = 1'b1;
            w_imm     = w_imm_s;
         end
         default: ;
      endcase
   end

   // Strobes are set on the transition into the state that owns them.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_durum        <= GETIR;
         r_ps           <= 32'h0;
         r_buyruk       <= NOP;
         r_buyruk_istek <= 1'b1;
         r_bellek_istek <= 1'b0;
         r_bellek_yaz   <= 1'b0;
         r_yazmac_yaz   <= 1'b0;
         r_gecersiz     <= 1'b0;
      end else begin
         case (r_durum)
            GETIR: begin
               if (bus.buyruk_gecerli_i) begin
                  r_buyruk       <= bus.buyruk_i;
                  r_buyruk_istek <= 1'b0;
                  r_durum        <= COZ;
               end
            end
            COZ: begin
               if (w_gecerli) begin
                  r_durum <= YURUT;
               end else begin
                  r_gecersiz <= 1'b1;
                  r_durum    <= HATA;
               end
            end
            YURUT: begin
               if (w_bellek_op) begin
                  r_bellek_istek <= 1'b1;
                  r_bellek_yaz   <= w_sw;
                  r_durum        <= BELLEK;
               end else begin
                  r_yazmac_yaz <= (w_rd != 5'd0);
                  r_durum      <= GERI_YAZ;
               end
            end
            BELLEK: begin
               if (bus.bellek_hazir_i) begin
                  r_bellek_istek <= 1'b0;
                  r_bellek_yaz   <= 1'b0;
                  if (w_sw) begin
                     r_ps           <= r_ps + 32'd4;
                     r_buyruk_istek <= 1'b1;
                     r_durum        <= GETIR;
                  end else begin
                     r_yazmac_yaz <= (w_rd != 5'd0);
                     r_durum      <= GERI_YAZ;
                  end
               end
            end
            GERI_YAZ: begin
               r_yazmac_yaz   <= 1'b0;
               r_ps           <= r_ps + 32'd4;
               r_buyruk_istek <= 1'b1;
               r_durum        <= GETIR;
            end
            HATA: ;
            default: begin
               r_buyruk_istek <= 1'b0;
               r_bellek_istek <= 1'b0;
               r_bellek_yaz   <= 1'b0;
               r_yazmac_yaz   <= 1'b0;
               r_gecersiz     <= 1'b1;
               r_durum        <= HATA;
            end
         endcase
      end
   end

   assign bus.buyruk_istek_o      = r_buyruk_istek;
   assign bus.ps_o                = r_ps;
   assign bus.amb_secim_o         = w_secim;
   assign bus.amb_fonksiyon_o     = w_fonk;
   assign bus.sabit_genisletici_o = w_imm;
   assign bus.rs1_adres_o         = r_buyruk[19:15];
   assign bus.rs2_adres_o         = r_buyruk[24:20];
   assign bus.rd_adres_o          = w_rd;
   assign bus.yazmac_yaz_o        = r_yazmac_yaz;
   assign bus.yaz_kaynak_o        = w_kaynak;
   assign bus.bellek_istek_o      = r_bellek_istek;
   assign bus.bellek_yaz_o        = r_bellek_yaz;
   assign bus.gecersiz_buyruk_o   = r_gecersiz;
endmodule

// File: tb/tb_denetim_birimi.sv
// Directed bench for denetim_birimi: instruction table plus hand-written memory-wait and reset sequences.
module tb_denetim_birimi;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   denetim_birimi_if bus();
   denetim_birimi dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] instr;
      logic        legal;
      logic [3:0]  fonk;
      logic        secim;
      logic [31:0] imm;
      logic [4:0]  rs1, rs2, rd;
      logic        kaynak;
      int          lat, wr, mem, mwr;
   } vec_t;

   vec_t vt[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_gecersiz", {31'b0, bus.gecersiz_buyruk_o}, 32'd0);
      chk("rst_ps", bus.ps_o, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("istek_after_rst", {31'b0, bus.buyruk_istek_o}, 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [31:0] ps0;
      logic [51:0] dec_exp, dec_act;
      int n, wr, mem, mwr;
      bit done;
      chk($sformatf("v%0d_istek", idx), {31'b0, bus.buyruk_istek_o}, 32'd1);
      ps0 = bus.ps_o;
      dec_exp = {v.fonk, v.secim, v.imm, v.rs1, v.rs2, v.rd, v.kaynak};
      bus.buyruk_i = v.instr;
      bus.buyruk_gecerli_i = 1'b1;
      bus.bellek_hazir_i = 1'b1;
      n = 0; wr = 0; mem = 0; mwr = 0; done = 1'b0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
         bus.buyruk_gecerli_i = 1'b0;
         bus.buyruk_i = 32'hDEAD_BEEF;
         wr  += int'(bus.yazmac_yaz_o);
         mem += int'(bus.bellek_istek_o);
         mwr += int'(bus.bellek_yaz_o);
         if (v.legal) begin
            dec_act = {bus.amb_fonksiyon_o, bus.amb_secim_o, bus.sabit_genisletici_o,
                       bus.rs1_adres_o, bus.rs2_adres_o, bus.rd_adres_o, bus.yaz_kaynak_o};
            if (n == 1) begin
               chk($sformatf("v%0d_fonk", idx), {28'b0, bus.amb_fonksiyon_o}, {28'b0, v.fonk});
               chk($sformatf("v%0d_secim", idx), {31'b0, bus.amb_secim_o}, {31'b0, v.secim});
               chk($sformatf("v%0d_imm", idx), bus.sabit_genisletici_o, v.imm);
               chk($sformatf("v%0d_rs1", idx), {27'b0, bus.rs1_adres_o}, {27'b0, v.rs1});
               chk($sformatf("v%0d_rs2", idx), {27'b0, bus.rs2_adres_o}, {27'b0, v.rs2});
               chk($sformatf("v%0d_rd", idx), {27'b0, bus.rd_adres_o}, {27'b0, v.rd});
               chk($sformatf("v%0d_kaynak", idx), {31'b0, bus.yaz_kaynak_o}, {31'b0, v.kaynak});
            end else if (dec_act !== dec_exp) begin
               checks++;
               errors++;
               $display("FAIL v%0d_stable cycle %0d actual=%h required=%h", idx, n, dec_act, dec_exp);
            end
            if (bus.buyruk_istek_o) done = 1'b1;
         end else if (bus.gecersiz_buyruk_o) begin
            done = 1'b1;
         end
      end
      if (v.legal) begin
         chk($sformatf("v%0d_latency", idx), n, v.lat);
         chk($sformatf("v%0d_wr", idx), wr, v.wr);
         chk($sformatf("v%0d_mem", idx), mem, v.mem);
         chk($sformatf("v%0d_memwr", idx), mwr, v.mwr);
         chk($sformatf("v%0d_ps", idx), bus.ps_o, ps0 + 32'd4);
         chk($sformatf("v%0d_gecersiz", idx), {31'b0, bus.gecersiz_buyruk_o}, 32'd0);
      end else begin
         chk($sformatf("v%0d_hata_delay", idx), n, 2);
         chk($sformatf("v%0d_hata_strobes", idx), wr + mem + mwr, 0);
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("v%0d_hata_hold", idx),
                {27'b0, bus.gecersiz_buyruk_o, bus.buyruk_istek_o, bus.yazmac_yaz_o,
                 bus.bellek_istek_o, bus.bellek_yaz_o}, 32'h10);
         end
         do_reset();
      end
   endtask

   initial begin
      int cnt, wr, n;
      logic [31:0] ps0;
      vt[0]  = '{32'h002081B3, 1'b1, 4'h0, 1'b0, 32'h0,        5'd1, 5'd2,  5'd3,  1'b0, 4, 1, 0, 0};
      vt[1]  = '{32'h407302B3, 1'b1, 4'h1, 1'b0, 32'h0,        5'd6, 5'd7,  5'd5,  1'b0, 4, 1, 0, 0};
      vt[2]  = '{32'h003170B3, 1'b1, 4'h2, 1'b0, 32'h0,        5'd2, 5'd3,  5'd1,  1'b0, 4, 1, 0, 0};
      vt[3]  = '{32'h00526033, 1'b1, 4'h4, 1'b0, 32'h0,        5'd4, 5'd5,  5'd0,  1'b0, 4, 0, 0, 0};
      vt[4]  = '{32'hFFF14193, 1'b1, 4'h3, 1'b1, 32'hFFFFFFFF, 5'd2, 5'd31, 5'd3,  1'b0, 4, 1, 0, 0};
      vt[5]  = '{32'h7FF47393, 1'b1, 4'h2, 1'b1, 32'h000007FF, 5'd8, 5'd31, 5'd7,  1'b0, 4, 1, 0, 0};
      vt[6]  = '{32'h8000E113, 1'b1, 4'h4, 1'b1, 32'hFFFFF800, 5'd1, 5'd0,  5'd2,  1'b0, 4, 1, 0, 0};
      vt[7]  = '{32'h0040A183, 1'b1, 4'h0, 1'b1, 32'h00000004, 5'd1, 5'd4,  5'd3,  1'b1, 5, 1, 1, 0};
      vt[8]  = '{32'hFE112E23, 1'b1, 4'h0, 1'b1, 32'hFFFFFFFC, 5'd2, 5'd1,  5'd28, 1'b0, 4, 0, 1, 1};
      vt[9]  = '{32'h00000000, 1'b0, 4'h0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 0, 0, 0, 0};
      vt[10] = '{32'h002091B3, 1'b0, 4'h0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 0, 0, 0, 0};
      vt[11] = '{32'h022081B3, 1'b0, 4'h0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 0, 0, 0, 0};
      vt[12] = '{32'h00408183, 1'b0, 4'h0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 0, 0, 0, 0};
      vt[13] = '{32'h403170B3, 1'b0, 4'h0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 0, 0, 0, 0};

      bus.buyruk_gecerli_i = 1'b0;
      bus.buyruk_i = 32'h0;
      bus.bellek_hazir_i = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      // Reset view is that of the NOP held in the instruction register.
      chk("rst_ps", bus.ps_o, 32'd0);
      chk("rst_secim", {31'b0, bus.amb_secim_o}, 32'd1);
      chk("rst_fonk", {28'b0, bus.amb_fonksiyon_o}, 32'd0);
      chk("rst_imm", bus.sabit_genisletici_o, 32'd0);
      chk("rst_adres", {17'b0, bus.rs1_adres_o, bus.rs2_adres_o, bus.rd_adres_o}, 32'd0);
      chk("rst_strobes", {28'b0, bus.yaz_kaynak_o, bus.yazmac_yaz_o, bus.bellek_istek_o,
                          bus.bellek_yaz_o}, 32'd0);
      chk("rst_gecersiz", {31'b0, bus.gecersiz_buyruk_o}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("istek_first_cycle", {31'b0, bus.buyruk_istek_o}, 32'd1);

      // No valid instruction: GETIR must hold without side effects.
      repeat (3) @(negedge clk);
      chk("idle_istek", {31'b0, bus.buyruk_istek_o}, 32'd1);
      chk("idle_ps", bus.ps_o, 32'd0);
      chk("idle_rd", {27'b0, bus.rd_adres_o}, 32'd0);

      for (int i = 0; i < 14; i++) run_vec(vt[i], i);

      // SW with data memory ready in the fourth BELLEK cycle.
      ps0 = bus.ps_o;
      bus.buyruk_i = 32'hFE112E23;
      bus.buyruk_gecerli_i = 1'b1;
      bus.bellek_hazir_i = 1'b0;
      cnt = 0; wr = 0; n = 0;
      do begin
         @(negedge clk);
         n++;
         bus.buyruk_gecerli_i = 1'b0;
         wr += int'(bus.yazmac_yaz_o);
         if (bus.bellek_istek_o) begin
            cnt++;
            chk("sw_wait_yaz", {31'b0, bus.bellek_yaz_o}, 32'd1);
            if (cnt == 4) bus.bellek_hazir_i = 1'b1;
         end
      end while (!bus.buyruk_istek_o && n < 30);
      bus.bellek_hazir_i = 1'b0;
      chk("sw_wait_cycles", cnt, 4);
      chk("sw_wait_no_wr", wr, 0);
      chk("sw_wait_ps", bus.ps_o, ps0 + 32'd4);
      chk("sw_wait_getir", {31'b0, bus.buyruk_istek_o}, 32'd1);

      // Reset while an LW waits on memory.
      bus.buyruk_i = 32'h0040A183;
      bus.buyruk_gecerli_i = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         bus.buyruk_gecerli_i = 1'b0;
      end while (!bus.bellek_istek_o && n < 20);
      chk("lw_reach_bellek", {31'b0, bus.bellek_istek_o}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_bellek_istek", {31'b0, bus.bellek_istek_o}, 32'd0);
      chk("abort_ps", bus.ps_o, 32'd0);
      chk("abort_wr", {31'b0, bus.yazmac_yaz_o}, 32'd0);
      chk("abort_rd", {27'b0, bus.rd_adres_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_restart_istek", {31'b0, bus.buyruk_istek_o}, 32'd1);
      run_vec(vt[0], 0);
      chk("abort_restart_ps", bus.ps_o, 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
